// File: rtl/divmod_unit.sv
// divmod_unit: iterative restoring divider, the inverse of a registered multiply-add stage.
// Computes A = DATA_IN / B and C = DATA_IN % B, one quotient bit per clock.
//
// Ports:
//   clk        single clock, all logic on posedge
//   reset      synchronous, active-high reset
//   in_valid   DATA_IN/B valid               in_ready   unit can accept an operand pair
//   DATA_IN    dividend                      B          divisor
//   out_valid  A/C/OVF/DIV0 valid            out_ready  consumer accepts result
//   A          quotient (all-ones on OVF or DIV0)
//   C          remainder
//   OVF        true quotient does not fit in SIZE_A bits
//   DIV0       divisor was zero
//
// Optional feature: define DIVMOD_EARLY_EXIT_EN to skip the bit loop when DATA_IN < B.
// Results are identical in both builds; only latency differs.

module divmod_unit #(
  parameter int unsigned SIZE_DATA_IN = 16,
  parameter int unsigned SIZE_B       = 8,
  parameter int unsigned SIZE_A       = 8,
  parameter int unsigned SIZE_C       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SIZE_DATA_IN-1:0] DATA_IN,
  input  logic [SIZE_B-1:0]       B,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIZE_A-1:0]       A,
  output logic [SIZE_C-1:0]       C,
  output logic                    OVF,
  output logic                    DIV0
);

  localparam int unsigned CntW = (SIZE_DATA_IN > 1) ? $clog2(SIZE_DATA_IN) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state;
  // Holds the dividend; quotient bits shift in at the LSB as dividend bits shift out the top.
  logic [SIZE_DATA_IN-1:0] work;
  logic [SIZE_B-1:0]       divisor;
  // One extra bit so the shifted partial remainder never overflows before the compare.
  logic [SIZE_B:0]         rem;
  logic [CntW-1:0]         cnt;
  logic                    div0_flag;

  logic [SIZE_B:0]         rem_shift;
  logic [SIZE_B:0]         rem_sub;
  logic                    q_bit;
  logic                    quo_ovf;
  logic                    early_exit;

  always_comb begin
    rem_shift = {rem[SIZE_B-1:0], work[SIZE_DATA_IN-1]};
    q_bit     = (rem_shift >= {1'b0, divisor});
    rem_sub   = rem_shift - {1'b0, divisor};
    quo_ovf   = |work[SIZE_DATA_IN-1:SIZE_A];
  end

`ifdef DIVMOD_EARLY_EXIT_EN
  assign early_exit = (DATA_IN < SIZE_DATA_IN'(B));
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      A         <= '0;
      C         <= '0;
      OVF       <= 1'b0;
      DIV0      <= 1'b0;
      work      <= '0;
      divisor   <= '0;
      rem       <= '0;
      cnt       <= '0;
      div0_flag <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            divisor   <= B;
            div0_flag <= (B == '0);
            if (B == '0) begin
              // Keep the dividend so its low bits can be returned as C.
              work  <= DATA_IN;
              rem   <= '0;
              state <= StDone;
            end else if (early_exit) begin
              work  <= '0;
              rem   <= DATA_IN[SIZE_B:0];
              state <= StDone;
            end else begin
              work  <= DATA_IN;
              rem   <= '0;
              cnt   <= CntW'(SIZE_DATA_IN - 1);
              state <= StCalc;
            end
          end
        end

        StCalc: begin
          work <= {work[SIZE_DATA_IN-2:0], q_bit};
          rem  <= q_bit ? rem_sub : rem_shift;
          if (cnt == '0) begin
            state <= StDone;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        StDone: begin
          // First DONE cycle publishes the result; afterwards hold until the consumer takes it.
          if (!out_valid) begin
            out_valid <= 1'b1;
            DIV0      <= div0_flag;
            OVF       <= !div0_flag && quo_ovf;
            A         <= (div0_flag || quo_ovf) ? '1 : work[SIZE_A-1:0];
            C         <= div0_flag ? work[SIZE_C-1:0] : SIZE_C'(rem);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
